// File: rtl/xpmwrap_fifo_rd_stream.sv
// Read-side drain stage for the async FIFO wrapper: turns a latency-1 standard-mode
// read port into a framed valid/ready stream backed by a two-entry output buffer.
module xpmwrap_fifo_rd_stream #(
   parameter int DATA_WIDTH    = 32,
   parameter int PKT_LEN       = 16,
   parameter int PKT_CNT_WIDTH = 16
) (
   input  logic                     rd_clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    fifo_dout,
   input  logic                     fifo_empty,
   input  logic                     fifo_rd_rst_busy,
   output logic                     fifo_rd_en,
   output logic [DATA_WIDTH-1:0]    m_data,
   output logic                     m_valid,
   output logic                     m_last,
   input  logic                     m_ready,
   output logic [PKT_CNT_WIDTH-1:0] pkt_count
);

   localparam int            BW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BW-1:0] BEAT_MAX = BW'(PKT_LEN - 1);

   logic [1:0]            occ;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] tail;
   logic [BW-1:0]         beat;
   logic                  pop;
   logic [2:0]            level;

   // m_data is the buffer head; m_valid/m_last decode registered state only
   assign m_valid = (occ != 2'd0);
   assign m_last  = m_valid & (beat == BEAT_MAX);
   assign pop     = m_valid & m_ready;
   assign level   = {1'b0, occ} + {2'b00, inflight};

   // a pop this cycle frees a slot for a read issued this cycle
   assign fifo_rd_en = ~rst & ~fifo_empty & ~fifo_rd_rst_busy &
                       ((level < 3'd2) | ((level == 3'd2) & pop));

   always_ff @(posedge rd_clk or posedge rst) begin
      if (rst) begin
         occ       <= 2'd0;
         inflight  <= 1'b0;
         m_data    <= '0;
         tail      <= '0;
         beat      <= '0;
         pkt_count <= '0;
      end else begin
         inflight <= fifo_rd_en;
         if (pop) begin
            beat <= (beat == BEAT_MAX) ? '0 : beat + 1'b1;
            if (m_last)
               pkt_count <= pkt_count + 1'b1;
         end
         case ({inflight, pop})
            2'b10: begin
               if (occ == 2'd0)
                  m_data <= fifo_dout;
               else
                  tail <= fifo_dout;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               if (occ == 2'd2)
                  m_data <= tail;
               occ <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  m_data <= fifo_dout;
               end else begin
                  m_data <= tail;
                  tail   <= fifo_dout;
               end
            end
            default: ;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge rd_clk) disable iff (rst)
      (occ != 2'd3) && !(inflight && !pop && occ == 2'd2));

endmodule

// File: tb/tb_xpmwrap_fifo_rd_stream.sv
// Scoreboard bench for xpmwrap_fifo_rd_stream: behavioural latency-1 FIFOs feed a
// PKT_LEN=4 and a PKT_LEN=1 instance; a negedge monitor checks every popped beat.
module tb_xpmwrap_fifo_rd_stream;
   localparam int DW = 32;
   localparam int PL = 4;
   localparam int CW = 16;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   logic          rd_clk = 1'b0;
   logic          rst;
   logic [DW-1:0] fifo_dout;
   logic          fifo_empty;
   logic          busy;
   logic          fifo_rd_en;
   logic [DW-1:0] m_data;
   logic          m_valid, m_last, m_ready;
   logic [CW-1:0] pkt_count;

   logic [DW-1:0] fifo_dout1;
   logic          fifo_empty1;
   logic          busy1;
   logic          fifo_rd_en1;
   logic [DW-1:0] m_data1;
   logic          m_valid1, m_last1, m_ready1;
   logic [CW-1:0] pkt_count1;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] fq1[$];
   exp_t          eq[$];
   logic [DW-1:0] eq1[$];
   int exp_beat = 0, pop_beat = 0, exp_pkt = 0, held = 0;
   int rd_total = 0, pop_total = 0, cyc = 0;
   int first_pop_cyc = -1, last_pop_cyc = -1;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   logic [DW-1:0] word_id = '0;

   always #5 rd_clk = ~rd_clk;

   xpmwrap_fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PL), .PKT_CNT_WIDTH(CW)) u_dut (
      .rd_clk(rd_clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_rst_busy(busy), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
      .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .pkt_count(pkt_count));

   xpmwrap_fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(1), .PKT_CNT_WIDTH(CW)) u_dut1 (
      .rd_clk(rd_clk), .rst(rst), .fifo_dout(fifo_dout1), .fifo_empty(fifo_empty1),
      .fifo_rd_rst_busy(busy1), .fifo_rd_en(fifo_rd_en1), .m_data(m_data1),
      .m_valid(m_valid1), .m_last(m_last1), .m_ready(m_ready1), .pkt_count(pkt_count1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      fq.push_back(w);
      fifo_empty = 1'b0;
      eq.push_back('{d: w, l: (exp_beat == PL - 1)});
      exp_beat = (exp_beat + 1) % PL;
   endtask

   task automatic push_next();
      push_word(word_id);
      word_id = word_id + 1'b1;
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n = 0;
      while ((eq.size() != 0 || held != 0) && n < budget) begin
         tick();
         n++;
      end
      chk({name, "_drain_left"}, eq.size(), 0);
   endtask

   // latency-1 FIFO models
   always @(posedge rd_clk) begin
      cyc++;
      if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      fifo_empty <= (fq.size() == 0);
      if (fifo_rd_en1 && fq1.size() > 0) fifo_dout1 <= fq1.pop_front();
      fifo_empty1 <= (fq1.size() == 0);
   end

   // scoreboard monitor
   always @(negedge rd_clk) begin
      if (!rst) begin
         if (fifo_rd_en) begin
            rd_total++;
            chk("rd_en_while_empty_or_busy", {fifo_empty, busy}, 2'b00);
         end
         if (prev_stall) begin
            chk("stall_data_stable", m_data, prev_data);
            chk("stall_last_stable", m_last, prev_last);
         end
         if (m_valid && m_ready) begin
            if (eq.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               exp_t e;
               e = eq.pop_front();
               chk("beat_data", m_data, e.d);
               chk("beat_last", m_last, e.l);
               if (e.l) exp_pkt++;
            end
            if (pop_total == 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            pop_total++;
            pop_beat = (pop_beat + 1) % PL;
         end
         held = held + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
         checks++;
         if (held > 2 || held < 0) begin
            errors++;
            $display("FAIL outstanding_words: got %0d required 0..2", held);
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;

         if (m_valid1 && m_ready1) begin
            chk("len1_last", m_last1, 1);
            if (eq1.size() == 0) chk("len1_unexpected_beat", 1, 0);
            else chk("len1_data", m_data1, eq1.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, cyc0, n;
      rst = 1'b1; m_ready = 1'b0; busy = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
      m_ready1 = 1'b0; busy1 = 1'b0; fifo_empty1 = 1'b1; fifo_dout1 = '0;
      tick(); tick();

      // reset state with a preloaded FIFO
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) push_next();
      tick();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_rd_en", fifo_rd_en, 0);

      // basic stream: words 0..7
      rst = 1'b0;
      #1;
      cyc0 = cyc;
      chk("basic_first_rd_en", fifo_rd_en, 1);
      wait_drain(50, "basic");
      chk("basic_first_pop_cycle", first_pop_cyc, cyc0 + 2);
      chk("basic_last_pop_cycle", last_pop_cyc, cyc0 + 9);
      chk("basic_pkt_count", pkt_count, 2);

      // backpressure: 5 words, 10 stalled cycles
      m_ready = 1'b0;
      r0 = rd_total;
      for (int i = 0; i < 5; i++) push_next();
      repeat (10) tick();
      chk("bp_rd_pulses", rd_total - r0, 2);
      chk("bp_valid", m_valid, 1);
      chk("bp_head_data", m_data, 8);
      m_ready = 1'b1;
      #1;
      chk("bp_release_rd_en", fifo_rd_en, 1);
      wait_drain(50, "bp");
      chk("bp_pkt_count", pkt_count, exp_pkt);

      // random handshake and refill
      n = 0;
      while (n < 1000) begin
         m_ready = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 3) != 0) begin
            push_next();
            n++;
         end
         tick();
      end
      m_ready = 1'b1;
      wait_drain(2000, "random");
      chk("random_pkt_count", pkt_count, exp_pkt);

      // rd_rst_busy mid-stream
      for (int i = 0; i < 12; i++) push_next();
      tick(); tick(); tick();
      busy = 1'b1;
      r0 = rd_total;
      repeat (5) tick();
      chk("busy_rd_pulses", rd_total - r0, 0);
      busy = 1'b0;
      wait_drain(100, "busy");
      chk("busy_pkt_count", pkt_count, exp_pkt);

      // async reset right after beat 2 of a packet
      for (int i = 0; i < 8; i++) push_next();
      n = 0;
      while (!(pop_beat == 3 && m_valid) && n < 50) begin
         tick();
         n++;
      end
      m_ready = 1'b0;
      chk("pre_reset_last", m_last, 1);
      #2;
      rst = 1'b1;
      fq.delete(); eq.delete();
      exp_beat = 0; pop_beat = 0; exp_pkt = 0; held = 0; prev_stall = 1'b0;
      fifo_empty = 1'b1;
      #1;
      chk("async_rst_valid", m_valid, 0);
      chk("async_rst_last", m_last, 0);
      chk("async_rst_pkt_count", pkt_count, 0);
      tick(); tick();
      rst = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_next();
      wait_drain(50, "post_reset");
      chk("post_reset_pkt_count", pkt_count, 1);

      // PKT_LEN=1 instance: 3 words
      m_ready1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fq1.push_back(DW'(32'hA0 + i));
         eq1.push_back(DW'(32'hA0 + i));
      end
      fifo_empty1 = 1'b0;
      n = 0;
      while ((eq1.size() != 0 || m_valid1) && n < 50) begin
         tick();
         n++;
      end
      chk("len1_drain_left", eq1.size(), 0);
      chk("len1_pkt_count", pkt_count1, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
